aes_sub_bytes_sched: RTL
========================

# aes_sub_bytes_sched

Time-multiplexed SubBytes engine that shares one 4-S-box lane between two requesters: the cipher-state datapath, which issues 128-bit SubBytes/InvSubBytes operations, and the key-expansion path, which issues 32-bit SubWord operations. Each 128-bit state is processed column by column over four cycles, which cuts S-box area by 4x compared with a full 16-S-box SubBytes stage. The block sits between the AES cipher core control and the key-expansion unit. Each requester has independent valid/ready input and output channels, and one arbiter never preempts an operation in flight.

## Interface
- KeyPrio, default 1'b0: 0 = round-robin between requesters; 1 = key requester always wins ties.
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- clear_i  in  1  synchronous abort; takes precedence over all other inputs except reset
- st_in_valid_i  in  1  state request valid
- st_in_ready_o  out  1  state request accepted
- st_mode_i  in  1  0 = forward S-box, 1 = inverse; sampled on accept
- st_data_i  in  128  state input; column c = bits [32c+:32]
- st_out_valid_o  out  1  substituted state valid
- st_out_ready_i  in  1  state consumer ready
- st_data_o  out  128  substituted state
- key_in_valid_i  in  1  SubWord request valid
- key_in_ready_o  out  1  SubWord request accepted
- key_data_i  in  32  word input
- key_out_valid_o  out  1  SubWord result valid
- key_out_ready_i  in  1  key consumer ready
- key_data_o  out  32  substituted word; always forward S-box
- busy_o  out  1  FSM not in IDLE

## Operation
- Single 128-bit data register `data_q`, 2-bit column counter `col_q`, mode register `mode_q`, and round-robin pointer `last_key_q`.
- FSM states:
  - IDLE
    - Arbitration: if only one requester is valid, grant it. If both are valid, grant key when KeyPrio=1; otherwise grant the requester not served last.
    - Ready outputs are asserted only in IDLE, only for the granted requester. Ready may depend on the other requester's valid.
    - On a state accept: `data_q` ← st_data_i, `mode_q` ← st_mode_i, `col_q` ← 0, go to ST_SUB.
    - On a key accept: `data_q[31:0]` ← key_data_i, `mode_q` ← 0, go to KEY_SUB.
  - ST_SUB: `data_q[32*col_q+:32]` ← sub_word(that column, `mode_q`) and `col_q` increments. The write at `col_q`=3 goes to ST_OUT.
  - ST_OUT: st_out_valid_o=1. On st_out_ready_i, go to IDLE and set `last_key_q` ← 0.
  - KEY_SUB: `data_q[31:0]` ← sub_word(`data_q[31:0]`, forward), go to KEY_OUT.
  - KEY_OUT: key_out_valid_o=1. On key_out_ready_i, go to IDLE and set `last_key_q` ← 1.
- Data outputs:
  - st_data_o = `data_q`; key_data_o = `data_q[31:0]`.
  - Both are stable while the corresponding valid is high.
- No preemption. A pending request waits in IDLE until the current operation's output handshake completes.
- clear_i: FSM → IDLE, `data_q` ← 0, `col_q` ← 0, `mode_q` ← 0. Any in-flight result is discarded, and no valid is asserted for it. `last_key_q` is unchanged.

## Timing
- Reset values: FSM = IDLE, `data_q` = 0, `col_q` = 0, `mode_q` = 0, `last_key_q` = 1, so the state requester wins the first tie.
- Reset values of outputs: all valid/ready outputs = 0, busy_o = 0, st_data_o = 0, key_data_o = 0.
- State path: accepted in cycle T; ST_SUB in T+1..T+4; st_out_valid_o high from T+5. Minimum 6 cycles between consecutive accepts.
- Key path: accepted in cycle T; KEY_SUB in T+1; key_out_valid_o high from T+2. Minimum 3 cycles between consecutive accepts.
- One bubble cycle (IDLE) follows every output handshake; no accept occurs in the same cycle as an output handshake.
- S-box lane is combinational; its only register is `data_q`. Critical path is one S-box plus the column mux.
- Back-pressure: valid is held indefinitely while ready is low, with data unchanged.
- Reset or clear in any state takes effect at the next edge. ready is 0 in the clear cycle.

## Structure
- Shared package `aes_pkg`:
  - `ciph_op_e` (CIPH_FWD = 1'b0, CIPH_INV = 1'b1)
  - `sbs_state_e` (IDLE, ST_SUB, ST_OUT, KEY_SUB, KEY_OUT)
- Sub-module `aes_sub_word`: four instances of the existing S-box LUT with a shared mode input, 32 bits in and 32 bits out. It is instantiated once here and is also reusable by key expansion.

## Test plan
- State request, 128'h0 with mode 0, accepted at T → st_out_valid_o rises at T+5 with st_data_o = 128'h6363…63. Same input with mode 1 → 128'h5252…52.
- Key request 32'h00010203 → key_out_valid_o rises at T+2 with key_data_o = 32'h637c777b. State requester idle throughout.
- Both valid from reset (KeyPrio=0) → state granted first, key second, then state again. With KeyPrio=1 → key always first.
- st_out_ready_i held low for 10 cycles with key_in_valid_i high → st_data_o stable, key_in_ready_o = 0 until the handshake plus one bubble.
- clear_i asserted at T+2 of a state operation → IDLE next cycle, no st_out_valid_o, st_data_o = 0. A new request then completes normally.
- rst_ni low mid-KEY_OUT → all outputs at reset values next cycle. The first tie after reset goes to the state requester.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types plus the S-box arithmetic used by the SubBytes lane.
// Each S-box is the GF(2^8) inverse wrapped in the forward or inverse affine map.
package aes_pkg;

    typedef enum logic {
        CIPH_FWD = 1'b0,
        CIPH_INV = 1'b1
    } ciph_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ST_SUB  = 3'd1,
        ST_OUT  = 3'd2,
        KEY_SUB = 3'd3,
        KEY_OUT = 3'd4
    } sbs_state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? (p ^ x) : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] e;
        r = 8'h01;
        e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            r = e[i] ? gf_mul(r, a) : r;
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// One 8-bit S-box (forward or inverse) and a 32-bit word lane of four of them.
// The lane is purely combinational; callers register the result.
module aes_sbox
    import aes_pkg::*;
(
    input  ciph_op_e   op,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = (op == CIPH_INV) ? sbox_inv(din) : sbox_fwd(din);

endmodule

module aes_sub_word
    import aes_pkg::*;
(
    input  ciph_op_e    op,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .op   (op),
            .din  (din[8*g +: 8]),
            .dout (dout[8*g +: 8])
        );
    end

endmodule

// File: rtl/aes_sub_bytes_sched.sv
// SubBytes engine sharing one 32-bit S-box lane between the cipher state path
// (four column passes) and the key-expansion SubWord path; no preemption.
module aes_sub_bytes_sched
    import aes_pkg::*;
#(
    parameter logic KeyPrio = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         st_in_valid_i,
    output logic         st_in_ready_o,
    input  logic         st_mode_i,
    input  logic [127:0] st_data_i,
    output logic         st_out_valid_o,
    input  logic         st_out_ready_i,
    output logic [127:0] st_data_o,
    input  logic         key_in_valid_i,
    output logic         key_in_ready_o,
    input  logic [31:0]  key_data_i,
    output logic         key_out_valid_o,
    input  logic         key_out_ready_i,
    output logic [31:0]  key_data_o,
    output logic         busy_o
);

    sbs_state_e   state_q;
    sbs_state_e   state_d;
    logic [127:0] data_q;
    logic [1:0]   col_q;
    ciph_op_e     mode_q;
    logic         last_key_q;

    logic         grant_key;
    logic         grant_st;
    logic         st_accept;
    logic         key_accept;
    logic [31:0]  lane_in;
    logic [31:0]  lane_out;
    ciph_op_e     lane_op;

    // Tie-break: key wins when prioritised or when state was served last.
    always_comb begin
        grant_key = key_in_valid_i & (~st_in_valid_i | KeyPrio | ~last_key_q);
        grant_st  = st_in_valid_i & ~grant_key;
    end

    assign st_in_ready_o  = rst_ni & ~clear_i & (state_q == IDLE) & grant_st;
    assign key_in_ready_o = rst_ni & ~clear_i & (state_q == IDLE) & grant_key;
    assign st_accept      = st_in_valid_i & st_in_ready_o;
    assign key_accept     = key_in_valid_i & key_in_ready_o;

    // Select the word fed to the shared S-box lane.
    always_comb begin
        lane_in = data_q[32*col_q +: 32];
        lane_op = mode_q;
        if (state_q == KEY_SUB) begin
            lane_in = data_q[31:0];
            lane_op = CIPH_FWD;
        end else begin
            lane_op = mode_q;
        end
    end

    aes_sub_word u_lane (
        .op   (lane_op),
        .din  (lane_in),
        .dout (lane_out)
    );

    // Next-state logic and status outputs decoded from the current state.
    always_comb begin
        state_d         = state_q;
        st_out_valid_o  = (state_q == ST_OUT);
        key_out_valid_o = (state_q == KEY_OUT);
        busy_o          = (state_q != IDLE);
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (st_accept) begin
                        state_d = ST_SUB;
                    end else if (key_accept) begin
                        state_d = KEY_SUB;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ST_SUB:  state_d = (col_q == 2'd3) ? ST_OUT : ST_SUB;
                ST_OUT:  state_d = st_out_ready_i ? IDLE : ST_OUT;
                KEY_SUB: state_d = KEY_OUT;
                KEY_OUT: state_d = key_out_ready_i ? IDLE : KEY_OUT;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: load on accept, substitute one column per cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            data_q <= 128'h0;
            col_q  <= 2'd0;
            mode_q <= CIPH_FWD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (st_accept) begin
                        data_q <= st_data_i;
                        mode_q <= ciph_op_e'(st_mode_i);
                        col_q  <= 2'd0;
                    end else if (key_accept) begin
                        data_q[31:0] <= key_data_i;
                        mode_q       <= CIPH_FWD;
                    end else begin
                        mode_q <= mode_q;
                    end
                end
                ST_SUB: begin
                    data_q[32*col_q +: 32] <= lane_out;
                    col_q                  <= col_q + 2'd1;
                end
                KEY_SUB: data_q[31:0] <= lane_out;
                default: col_q <= col_q;
            endcase
        end
    end

    // Round-robin pointer survives clear so fairness is kept across aborts.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_key_q <= 1'b1;
        end else if (clear_i) begin
            last_key_q <= last_key_q;
        end else if ((state_q == ST_OUT) && st_out_ready_i) begin
            last_key_q <= 1'b0;
        end else if ((state_q == KEY_OUT) && key_out_ready_i) begin
            last_key_q <= 1'b1;
        end else begin
            last_key_q <= last_key_q;
        end
    end

    assign st_data_o  = data_q;
    assign key_data_o = data_q[31:0];

endmodule
